// File: rtl/sevenseg_scan_ctrl_if.sv
// Interface bundle for the seven-segment scan controller: the display
// data/strobe inputs and the decoder/anode/ack outputs. The controller
// uses the slave modport; whoever feeds it uses the master modport.
interface sevenseg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    enable;
   logic                    load;
   logic [4*NUM_DIGITS-1:0] values;
   logic [3:0]              digit;
   logic [NUM_DIGITS-1:0]   anodes;
   logic                    load_ack;

   modport master (
      output enable, load, values,
      input  digit, anodes, load_ack
   );

   modport slave (
      input  enable, load, values,
      output digit, anodes, load_ack
   );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode
// seven-segment display. One digit slot at a time: a short all-dark
// BLANK phase while the shared decoder settles on the new nibble, then a
// SHOW phase with that digit's active-low anode on. New display values are
// staged and only copied into the shadow (displayed) register at a frame
// boundary, or immediately while the display is switched off.
// Optional feature: define LEADING_ZERO_BLANK_EN to keep leading-zero
// digits dark (digit 0 is always shown).
module sevenseg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input logic                clk,
   input logic                reset,
   sevenseg_scan_ctrl_if.slave bus
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int VAL_W = 4 * NUM_DIGITS;

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [IDX_W-1:0]  idx, idx_d;
   logic [VAL_W-1:0]  staging, staging_d;
   logic [VAL_W-1:0]  shadow, shadow_d;
   logic              pending, pending_d;
   logic [3:0]        digit_q, digit_d;
   logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
   logic              ack_q, ack_d;
   logic              boundary;
   logic              apply;

   function automatic logic [3:0] nibble_at(input logic [VAL_W-1:0] v,
                                             input logic [IDX_W-1:0] i);
      logic [3:0] r;
      r = 4'h0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (i == IDX_W'(k)) r = v[k*4 +: 4];
      end
      return r;
   endfunction

`ifdef LEADING_ZERO_BLANK_EN
   function automatic logic lead_zero(input logic [VAL_W-1:0] v,
                                      input logic [IDX_W-1:0] i);
      logic z;
      z = (i != '0);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if ((IDX_W'(k) >= i) && (v[k*4 +: 4] != 4'h0)) z = 1'b0;
      end
      return z;
   endfunction
`endif

   // Next-state logic for the scan FSM and its slot counter / digit index
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      if (!bus.enable) begin
         state_d = OFF;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state)
            OFF: begin
               state_d = BLANK;
               cnt_d   = '0;
               idx_d   = '0;
            end
            BLANK: begin
               cnt_d = cnt + CNT_W'(1);
               if (cnt >= BLANK_LAST) state_d = SHOW;
            end
            SHOW: begin
               if (cnt == CNT_LAST) begin
                  state_d = BLANK;
                  cnt_d   = '0;
                  idx_d   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
               end else begin
                  cnt_d = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_d = OFF;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   // Load handshake: stage incoming values, promote them to the shadow at a frame boundary or while dark
   always_comb begin
      boundary  = bus.enable && (state == SHOW) && (cnt == CNT_LAST) && (idx == IDX_LAST);
      apply     = boundary || (state == OFF);
      staging_d = bus.load ? bus.values : staging;
      shadow_d  = shadow;
      pending_d = pending;
      ack_d     = 1'b0;
      if (apply) begin
         if (bus.load) shadow_d = bus.values;
         else if (pending) shadow_d = staging;
         ack_d     = bus.load || pending;
         pending_d = 1'b0;
      end else if (bus.load) begin
         pending_d = 1'b1;
      end
   end

   // Output decode from the upcoming state so that digit and anodes are registered and aligned with it
   always_comb begin
      digit_d  = digit_q;
      anodes_d = '1;
      if (state_d == BLANK) digit_d = nibble_at(shadow_d, idx_d);
      if (state_d == SHOW) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) anodes_d[k] = 1'b0;
         end
`ifdef LEADING_ZERO_BLANK_EN
         if (lead_zero(shadow_d, idx_d)) anodes_d = '1;
`endif
      end
   end

   // State, buffers and registered outputs with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= BLANK;
         cnt      <= '0;
         idx      <= '0;
         staging  <= '0;
         shadow   <= '0;
         pending  <= 1'b0;
         digit_q  <= 4'h0;
         anodes_q <= '1;
         ack_q    <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         idx      <= idx_d;
         staging  <= staging_d;
         shadow   <= shadow_d;
         pending  <= pending_d;
         digit_q  <= digit_d;
         anodes_q <= anodes_d;
         ack_q    <= ack_d;
      end
   end

   assign bus.digit    = digit_q;
   assign bus.anodes   = anodes_q;
   assign bus.load_ack = ack_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed self-checking bench for sevenseg_scan_ctrl with NUM_DIGITS=4,
// REFRESH_DIV=8, BLANK_CYCLES=2. Each slot is 8 cycles: 2 dark, 6 lit.
// Expected anodes are given both for the plain build and for a build with
// LEADING_ZERO_BLANK_EN defined.
module tb_sevenseg_scan_ctrl;

   localparam int N  = 4;
   localparam int RD = 8;
   localparam int BC = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int asserts  = 0;
   int failures = 0;

   sevenseg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

   sevenseg_scan_ctrl #(
      .NUM_DIGITS  (N),
      .REFRESH_DIV (RD),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Advance n clock edges, sampling 1 time unit after each edge; load is a one-cycle strobe
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         bus.load = 1'b0;
      end
   endtask

   // Single comparison point
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      asserts++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Walk one full slot starting at its first BLANK cycle, ending at the next slot's first BLANK cycle
   task automatic checkSlot(input string tag, input logic [3:0] d,
                            input logic [3:0] an, input logic [3:0] anLz,
                            input logic ack);
      logic [3:0] expAn;
`ifdef LEADING_ZERO_BLANK_EN
      expAn = anLz;
`else
      expAn = an;
`endif
      checkOutput({tag, "_blank0_anodes"}, 32'(bus.anodes), 32'hF);
      checkOutput({tag, "_digit"}, 32'(bus.digit), 32'(d));
      checkOutput({tag, "_ack0"}, 32'(bus.load_ack), 32'(ack));
      applyStimulus(1);
      checkOutput({tag, "_blank1_anodes"}, 32'(bus.anodes), 32'hF);
      checkOutput({tag, "_ack1"}, 32'(bus.load_ack), 32'h0);
      for (int i = 0; i < RD - BC; i++) begin
         applyStimulus(1);
         checkOutput({tag, "_show_anodes"}, 32'(bus.anodes), 32'(expAn));
         checkOutput({tag, "_show_digit"}, 32'(bus.digit), 32'(d));
      end
      applyStimulus(1);
   endtask

   initial begin
      bus.enable = 1'b0;
      bus.load   = 1'b0;
      bus.values = '0;

      // Reset state
      applyStimulus(3);
      checkOutput("reset_anodes", 32'(bus.anodes), 32'hF);
      checkOutput("reset_digit", 32'(bus.digit), 32'h0);
      checkOutput("reset_ack", 32'(bus.load_ack), 32'h0);

      // Test 1: release reset, enable, load 1234; first frame still shows the zero shadow
      reset      = 1'b0;
      bus.enable = 1'b1;
      bus.load   = 1'b1;
      bus.values = 16'h1234;
      checkSlot("t1_f0_s0", 4'h0, 4'b1110, 4'b1110, 1'b0);
      checkSlot("t1_f0_s1", 4'h0, 4'b1101, 4'b1111, 1'b0);
      checkSlot("t1_f0_s2", 4'h0, 4'b1011, 4'b1111, 1'b0);
      checkSlot("t1_f0_s3", 4'h0, 4'b0111, 4'b1111, 1'b0);
      checkSlot("t1_f1_s0", 4'h4, 4'b1110, 4'b1110, 1'b1);
      checkSlot("t1_f1_s1", 4'h3, 4'b1101, 4'b1101, 1'b0);
      checkSlot("t1_f1_s2", 4'h2, 4'b1011, 4'b1011, 1'b0);
      checkSlot("t1_f1_s3", 4'h1, 4'b0111, 4'b0111, 1'b0);

      // Test 2: two mid-frame loads; old digits held, single ack, last load wins
      checkSlot("t2_f2_s0", 4'h4, 4'b1110, 4'b1110, 1'b0);
      bus.load   = 1'b1;
      bus.values = 16'hABCD;
      applyStimulus(2);
      bus.load   = 1'b1;
      bus.values = 16'h5678;
      applyStimulus(1);
      checkOutput("t2_mid_digit", 32'(bus.digit), 32'h3);
      checkOutput("t2_mid_anodes", 32'(bus.anodes), 32'hD);
      checkOutput("t2_mid_ack", 32'(bus.load_ack), 32'h0);
      applyStimulus(5);
      checkSlot("t2_f2_s2", 4'h2, 4'b1011, 4'b1011, 1'b0);
      checkSlot("t2_f2_s3", 4'h1, 4'b0111, 4'b0111, 1'b0);
      checkSlot("t2_f3_s0", 4'h8, 4'b1110, 4'b1110, 1'b1);
      checkSlot("t2_f3_s1", 4'h7, 4'b1101, 4'b1101, 1'b0);
      checkSlot("t2_f3_s2", 4'h6, 4'b1011, 4'b1011, 1'b0);
      checkSlot("t2_f3_s3", 4'h5, 4'b0111, 4'b0111, 1'b0);

      // Test 3: load exactly in the frame-boundary cycle
      checkSlot("t3_f4_s0", 4'h8, 4'b1110, 4'b1110, 1'b0);
      checkSlot("t3_f4_s1", 4'h7, 4'b1101, 4'b1101, 1'b0);
      checkSlot("t3_f4_s2", 4'h6, 4'b1011, 4'b1011, 1'b0);
      checkOutput("t3_s3_digit", 32'(bus.digit), 32'h5);
      applyStimulus(7);
      checkOutput("t3_s3_last_anodes", 32'(bus.anodes), 32'h7);
      bus.load   = 1'b1;
      bus.values = 16'h0F00;
      applyStimulus(1);
      checkSlot("t3_f5_s0", 4'h0, 4'b1110, 4'b1110, 1'b1);
      checkSlot("t3_f5_s1", 4'h0, 4'b1101, 4'b1101, 1'b0);
      checkSlot("t3_f5_s2", 4'hF, 4'b1011, 4'b1011, 1'b0);
      checkSlot("t3_f5_s3", 4'h0, 4'b0111, 4'b1111, 1'b0);

      // Test 4: disable mid-slot, load while dark, re-enable restarts at digit 0
      applyStimulus(4);
      checkOutput("t4_pre_anodes", 32'(bus.anodes), 32'hE);
      bus.enable = 1'b0;
      applyStimulus(1);
      checkOutput("t4_off_anodes", 32'(bus.anodes), 32'hF);
      bus.load   = 1'b1;
      bus.values = 16'h9999;
      applyStimulus(1);
      checkOutput("t4_off_ack", 32'(bus.load_ack), 32'h1);
      checkOutput("t4_off_anodes2", 32'(bus.anodes), 32'hF);
      applyStimulus(1);
      checkOutput("t4_off_ack_clear", 32'(bus.load_ack), 32'h0);
      applyStimulus(17);
      checkOutput("t4_off_anodes3", 32'(bus.anodes), 32'hF);
      bus.enable = 1'b1;
      applyStimulus(1);
      checkSlot("t4_on_s0", 4'h9, 4'b1110, 4'b1110, 1'b0);

      // Test 5: reset mid-SHOW with a pending load; pending is dropped and shadow cleared
      bus.load   = 1'b1;
      bus.values = 16'h4321;
      applyStimulus(3);
      checkOutput("t5_pre_anodes", 32'(bus.anodes), 32'hD);
      reset = 1'b1;
      applyStimulus(1);
      checkOutput("t5_rst_anodes", 32'(bus.anodes), 32'hF);
      checkOutput("t5_rst_digit", 32'(bus.digit), 32'h0);
      checkOutput("t5_rst_ack", 32'(bus.load_ack), 32'h0);
      reset = 1'b0;
      checkSlot("t5_f0_s0", 4'h0, 4'b1110, 4'b1110, 1'b0);
      checkSlot("t5_f0_s1", 4'h0, 4'b1101, 4'b1111, 1'b0);
      checkSlot("t5_f0_s2", 4'h0, 4'b1011, 4'b1111, 1'b0);
      checkSlot("t5_f0_s3", 4'h0, 4'b0111, 4'b1111, 1'b0);

      // Test 6: leading-zero value 0070
      bus.load   = 1'b1;
      bus.values = 16'h0070;
      checkSlot("t6_f0_s0", 4'h0, 4'b1110, 4'b1110, 1'b0);
      checkSlot("t6_f0_s1", 4'h0, 4'b1101, 4'b1111, 1'b0);
      checkSlot("t6_f0_s2", 4'h0, 4'b1011, 4'b1111, 1'b0);
      checkSlot("t6_f0_s3", 4'h0, 4'b0111, 4'b1111, 1'b0);
      checkSlot("t6_f1_s0", 4'h0, 4'b1110, 4'b1110, 1'b1);
      checkSlot("t6_f1_s1", 4'h7, 4'b1101, 4'b1101, 1'b0);
      checkSlot("t6_f1_s2", 4'h0, 4'b1011, 4'b1111, 1'b0);
      checkSlot("t6_f1_s3", 4'h0, 4'b0111, 4'b1111, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
